// File: rtl/elev_call_panel.sv
// elev_call_panel -- elevator call panel front end.
// Synchronises and debounces eight floor-call buttons plus the add, remove
// and door-close buttons. Floor calls are latched in sw until the car
// stands at that floor with the door open. Passenger and door commands are
// forwarded as single-cycle pulses.
// Optional feature macro: CALL_CANCEL_EN -- a repeat press on a floor that
// is already requested cancels that request (toggle behaviour).
module elev_call_panel #(
    parameter int TICK_DIV    = 100000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:7] btn,
    input  logic       add_btn,
    input  logic       rem_btn,
    input  logic       close_btn,
    input  logic [0:7] floor,
    input  logic       open,
    output logic [0:7] sw,
    output logic       add,
    output logic       rem,
    output logic       close,
    output logic [0:3] call_cnt,
    output logic       bad_floor
);

    localparam int NCH      = 11;
    localparam int CH_ADD   = 8;
    localparam int CH_REM   = 9;
    localparam int CH_CLOSE = 10;
    localparam int PW       = $clog2(TICK_DIV);

    // Raw inputs gathered into one vector: 0..7 floors, then add, rem, close.
    logic [NCH-1:0] raw_w;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] ev_w;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_raw
            assign raw_w[gi] = btn[gi];
        end
    endgenerate
    assign raw_w[CH_ADD]   = add_btn;
    assign raw_w[CH_REM]   = rem_btn;
    assign raw_w[CH_CLOSE] = close_btn;

    // Two-flop synchronizer for every asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_w;
            sync2_q <= sync1_q;
        end
    end

    // Free-running prescaler; tick is high for one cycle every TICK_DIV cycles.
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    // One debouncer per channel. A sample equal to the accepted level
    // restarts the run; DEB_SAMPLES differing samples in a row accept the
    // new level. A 0->1 acceptance emits a one-cycle event right after the
    // accepting tick.
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_deb
            logic [3:0] cnt_q;
            logic [3:0] cnt_d;
            logic       lvl_q;
            logic       lvl_d;
            logic       ev_q;
            logic       ev_d;

            // Next-state for the sample counter, level and rising event.
            always_comb begin
                cnt_d = cnt_q;
                lvl_d = lvl_q;
                ev_d  = 1'b0;
                if (tick) begin
                    if (sync2_q[gi] == lvl_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == 4'(DEB_SAMPLES - 1)) begin
                        cnt_d = '0;
                        lvl_d = sync2_q[gi];
                        ev_d  = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            // Debouncer state registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                    ev_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                    ev_q  <= ev_d;
                end
            end

            assign ev_w[gi] = ev_q;
        end
    endgenerate

    // Output stage next-state.
    logic [0:7] sw_q;
    logic [0:7] sw_d;
    logic [0:3] call_cnt_q;
    logic [0:3] call_cnt_d;
    logic       add_q, add_d;
    logic       rem_q, rem_d;
    logic       close_q, close_d;
    logic       bad_floor_q, bad_floor_d;
    logic       floor_onehot;

    // Call latch with clear-on-arrival priority, popcount and command pulses.
    always_comb begin
        floor_onehot = (floor != '0) && ((floor & (floor - 8'd1)) == '0);
        call_cnt_d   = '0;
        sw_d         = sw_q;
        for (int i = 0; i < 8; i++) begin
`ifdef CALL_CANCEL_EN
            sw_d[i] = sw_q[i] ^ ev_w[i];
`else
            sw_d[i] = sw_q[i] | ev_w[i];
`endif
            // The car standing here with the door open serves the call.
            if (open && floor_onehot && floor[i]) begin
                sw_d[i] = 1'b0;
            end
            call_cnt_d = call_cnt_d + 4'(sw_d[i]);
        end
        // Passenger commands only make sense with the door open, and a
        // simultaneous add/remove is ambiguous so both are dropped.
        add_d       = ev_w[CH_ADD] & ~ev_w[CH_REM] & open;
        rem_d       = ev_w[CH_REM] & ~ev_w[CH_ADD] & open;
        close_d     = ev_w[CH_CLOSE];
        bad_floor_d = ~floor_onehot;
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q        <= '0;
            call_cnt_q  <= '0;
            add_q       <= 1'b0;
            rem_q       <= 1'b0;
            close_q     <= 1'b0;
            bad_floor_q <= 1'b0;
        end else begin
            sw_q        <= sw_d;
            call_cnt_q  <= call_cnt_d;
            add_q       <= add_d;
            rem_q       <= rem_d;
            close_q     <= close_d;
            bad_floor_q <= bad_floor_d;
        end
    end

    assign sw        = sw_q;
    assign call_cnt  = call_cnt_q;
    assign add       = add_q;
    assign rem       = rem_q;
    assign close     = close_q;
    assign bad_floor = bad_floor_q;

endmodule

// File: tb/tb_elev_call_panel.sv
// Directed testbench for elev_call_panel with TICK_DIV=4, DEB_SAMPLES=3.
module tb_elev_call_panel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:7] btn;
    logic       add_btn;
    logic       rem_btn;
    logic       close_btn;
    logic [0:7] floor;
    logic       open;
    logic [0:7] sw;
    logic       add;
    logic       rem;
    logic       close;
    logic [0:3] call_cnt;
    logic       bad_floor;

    int n_vec = 0;
    int n_err = 0;

    int         n_add, n_rem, n_close, n_bad, n_chg;
    logic [0:7] seen_mask;
    logic [0:7] sw_prev;

    elev_call_panel #(
        .TICK_DIV    (4),
        .DEB_SAMPLES (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .add_btn   (add_btn),
        .rem_btn   (rem_btn),
        .close_btn (close_btn),
        .floor     (floor),
        .open      (open),
        .sw        (sw),
        .add       (add),
        .rem       (rem),
        .close     (close),
        .call_cnt  (call_cnt),
        .bad_floor (bad_floor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic clr_mon();
        n_add     = 0;
        n_rem     = 0;
        n_close   = 0;
        n_bad     = 0;
        n_chg     = 0;
        seen_mask = '0;
        sw_prev   = sw;
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            n_add   += int'(add);
            n_rem   += int'(rem);
            n_close += int'(close);
            n_bad   += int'(bad_floor);
            if (sw !== sw_prev) n_chg++;
            sw_prev   = sw;
            seen_mask = seen_mask | sw;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn       = '0;
        add_btn   = 1'b0;
        rem_btn   = 1'b0;
        close_btn = 1'b0;
        floor     = 8'b00000001;
        open      = 1'b0;
        sw_prev   = '0;
        seen_mask = '0;

        // Reset state
        run(3);
        chk("rst_sw", 32'(sw), 32'h0);
        chk("rst_cnt", 32'(call_cnt), 32'h0);
        chk("rst_cmds", {29'h0, add, rem, close}, 32'h0);
        chk("rst_bad", 32'(bad_floor), 32'h0);
        rst_n = 1'b1;
        run(2);

        // Clean press of floor 5
        clr_mon();
        btn[5] = 1'b1;
        run(20);
        chk("p5_sw", 32'(sw), 32'(8'b00000100));
        chk("p5_cnt", 32'(call_cnt), 32'd1);
        chk("p5_once", 32'(n_chg), 32'd1);
        btn[5] = 1'b0;
        clr_mon();
        run(20);
        chk("p5_release", 32'(n_chg), 32'd0);

        // Bouncing floor 2, then stable
        clr_mon();
        for (int s = 0; s < 10; s++) begin
            btn[2] = (s % 2 == 0);
            run(3);
        end
        chk("bounce_quiet", 32'(seen_mask[2]), 32'd0);
        btn[2] = 1'b1;
        clr_mon();
        run(20);
        chk("bounce_sw", 32'(sw), 32'(8'b00100100));
        chk("bounce_cnt", 32'(call_cnt), 32'd2);
        chk("bounce_once", 32'(n_chg), 32'd1);
        btn[2] = 1'b0;
        run(20);

        // Arrival at floor 2
        floor = 8'b00100000;
        run(1);
        chk("closed_keep", 32'(sw), 32'(8'b00100100));
        open = 1'b1;
        run(1);
        chk("arrive_sw", 32'(sw), 32'(8'b00000100));
        chk("arrive_cnt", 32'(call_cnt), 32'd1);
        clr_mon();
        btn[2] = 1'b1;
        run(20);
        btn[2] = 1'b0;
        run(20);
        chk("arrive_press", 32'(seen_mask[2]), 32'd0);
        chk("arrive_sw2", 32'(sw), 32'(8'b00000100));

        // Passenger and door commands
        open = 1'b0;
        clr_mon();
        add_btn = 1'b1; run(20); add_btn = 1'b0; run(20);
        chk("add_closed", 32'(n_add), 32'd0);
        open = 1'b1;
        clr_mon();
        add_btn = 1'b1; run(20); add_btn = 1'b0; run(20);
        chk("add_open", 32'(n_add), 32'd1);
        chk("add_open_rem", 32'(n_rem), 32'd0);
        clr_mon();
        add_btn = 1'b1; rem_btn = 1'b1; run(20);
        add_btn = 1'b0; rem_btn = 1'b0; run(20);
        chk("both_add", 32'(n_add), 32'd0);
        chk("both_rem", 32'(n_rem), 32'd0);
        clr_mon();
        rem_btn = 1'b1; run(20); rem_btn = 1'b0; run(20);
        chk("rem_open", 32'(n_rem), 32'd1);
        open = 1'b0;
        clr_mon();
        close_btn = 1'b1; run(20); close_btn = 1'b0; run(20);
        chk("close_closed", 32'(n_close), 32'd1);

        // Fill all calls, then present bad floor codes with door open
        clr_mon();
        btn = 8'b11111011;
        run(20);
        btn = '0;
        run(20);
        chk("fill_sw", 32'(sw), 32'hFF);
        chk("fill_cnt", 32'(call_cnt), 32'd8);
        open  = 1'b1;
        floor = 8'b00000000;
        clr_mon();
        run(3);
        chk("zero_sw", 32'(sw), 32'hFF);
        chk("zero_bad", 32'(n_bad), 32'd3);
        floor = 8'b00011000;
        clr_mon();
        run(3);
        chk("multi_sw", 32'(sw), 32'hFF);
        chk("multi_bad", 32'(n_bad), 32'd3);
        floor = 8'b10000000;
        clr_mon();
        run(1);
        chk("good_bad", 32'(n_bad), 32'd0);
        chk("good_sw", 32'(sw), 32'(8'b01111111));
        chk("good_cnt", 32'(call_cnt), 32'd7);
        open = 1'b0;

        // Repeat press on an already-requested floor
        btn[3] = 1'b1; run(20); btn[3] = 1'b0; run(20);
`ifdef CALL_CANCEL_EN
        chk("repeat_sw", 32'(sw), 32'(8'b01101111));
        chk("repeat_cnt", 32'(call_cnt), 32'd6);
`else
        chk("repeat_sw", 32'(sw), 32'(8'b01111111));
        chk("repeat_cnt", 32'(call_cnt), 32'd7);
`endif

        // Reset mid-press, button held through release
        btn[0] = 1'b1;
        run(8);
        rst_n = 1'b0;
        #1;
        chk("arst_sw", 32'(sw), 32'h0);
        chk("arst_cnt", 32'(call_cnt), 32'h0);
        chk("arst_cmds", {29'h0, add, rem, close}, 32'h0);
        run(2);
        rst_n = 1'b1;
        clr_mon();
        run(12);
        chk("held_no_early", 32'(sw), 32'h0);
        run(8);
        chk("held_sw", 32'(sw), 32'(8'b10000000));
        chk("held_cnt", 32'(call_cnt), 32'd1);
        chk("held_once", 32'(n_chg), 32'd1);
        btn[0] = 1'b0;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
